operand_collector: RTL
======================

# operand_collector

Sits between decode and execute in the CUDA core and gathers up to three source operands per instruction through the register file's single combinational read port. It reads one operand per cycle and stays coherent with writeback by snooping the register file write bus. It then presents the complete operand bundle to execute over a valid/ready handshake. This serialises multi-source instructions onto the one read port without stale-operand hazards.

## Interface
- `XLEN`, 32: data width.
- `REG_AW`, 5: register address width (32 registers; x0 hard-wired zero).
- `CTRL_W`, 16: opaque decode control bits passed through unchanged.
- `clk`  in  1  core clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  decode offers an instruction.
- `in_ready`  out  1  collector accepts this cycle.
- `in_nsrc`  in  2  number of sources, 0–3; a value of 3 uses `rs1`, `rs2` and `rs3`.
- `in_rs1`, `in_rs2`, `in_rs3`  in  REG_AW each  source register indices.
- `in_rd`  in  REG_AW  destination, passed through.
- `in_imm`  in  XLEN  immediate, passed through.
- `in_ctrl`  in  CTRL_W  passed through.
- `rf_adr`  out  REG_AW  register file read address.
- `rf_rs`  in  XLEN  register file read data (combinational from `rf_adr`).
- `wb_we`  in  1  writeback write enable (same signal the register file uses as `RF_WE`).
- `wb_adr`  in  REG_AW  writeback address.
- `wb_data`  in  XLEN  writeback data.
- `out_valid`  out  1  bundle complete.
- `out_ready`  in  1  execute accepts.
- `out_a`, `out_b`, `out_c`  out  XLEN each  operands for `rs1`, `rs2`, `rs3`.
- `out_rd`, `out_imm`, `out_ctrl`  out  pass-through fields, registered at accept.

## Operation
- **States:**
  - IDLE: empty.
  - READ: collecting, with slot counter `idx` 0..nsrc-1.
  - HOLD: bundle valid, waiting for execute.
- **`in_ready`:**
  - High in IDLE.
  - High in HOLD while `out_ready` is high.
  - Low in READ.
  - Low while `rst` is high.
- **Accept** (`in_valid && in_ready`):
  - Latch `rs1`–`rs3`, `nsrc`, `rd`, `imm` and `ctrl`.
  - Zero all three operand slots.
  - `idx` := 0.
  - Next state is READ if nsrc>0, else HOLD.
- **READ:**
  - `rf_adr` = rs[`idx`].
  - At posedge, slot[`idx`] captures `rf_rs`. If rs[`idx`]==0 it captures 0 instead.
  - `idx` increments; after slot nsrc-1 the next state is HOLD.
- **`rf_adr`:** 0 in IDLE and HOLD.
- **Snoop:**
  - Applies in READ and HOLD, every cycle `wb_we && wb_adr!=0`.
  - Each already-filled slot whose index equals `wb_adr` loads `wb_data`.
  - The slot being captured this cycle also takes `wb_data` if its index matches. This agrees with `rf_rs`, because the register file writes on negedge.
  - Unused slots (≥ nsrc) never snoop and stay 0.
- **HOLD:**
  - `out_valid`=1 and outputs are stable.
  - On `out_ready`: if a new instruction is also accepted in the same cycle, the next state is READ or HOLD per the new nsrc. Otherwise the next state is IDLE.
- **Writes to x0** are ignored by the snoop.

## Timing
- **Reset values:** state IDLE; `out_valid` 0; `out_a`/`out_b`/`out_c`/`out_imm` 0; `out_rd` 0; `out_ctrl` 0; `rf_adr` 0; `idx` 0.
- **Latency:** accept at cycle T gives `out_valid` at T+nsrc+1. With nsrc=0, valid at T+1.
- **Throughput:** one instruction per nsrc+1 cycles, or one per cycle when nsrc=0 and execute is always ready.
- **Back-to-back:** accepting in HOLD together with `out_ready` produces no bubble beyond the READ cycles.
- **Reset mid-operation:** `rst` in READ or HOLD drops the instruction in progress. On the next cycle the block is in IDLE with `out_valid` 0; no partial bundle is ever presented.
- **Handshake rules:**
  - `out_valid` never falls without `out_ready`.
  - Outputs never change while `out_valid && !out_ready`, except by snoop updates.
- **Snoop updates in HOLD** are visible on the cycle after the write.

## Structure
- **Shared `core_pkg`:** `XLEN`, `REG_AW`, `NUM_SRC`=3, and `oc_state_t` enum {IDLE, READ, HOLD}.
- **Sub-module `oc_slot`:** one operand register plus its source index, a filled flag and snoop-compare logic; instantiated three times.
- **Top:** holds the FSM, `idx` counter, read-address mux and pass-through registers.

## Test plan
- **Basic collect:** RF x5=0x11, x6=0x22, x7=0x33; accept nsrc=3 (5,6,7) at T. Expect `rf_adr` 5,6,7 on T+1..T+3 and `out_valid` at T+4 with a/b/c = 0x11/0x22/0x33.
- **nsrc=0 and x0:** nsrc=0 gives valid at T+1 with a=b=c=0. nsrc=2 (0,6) gives a=0 and b=0x22.
- **Snoop:** nsrc=2 (5,6). Writeback x5=0xAA during the cycle slot b is read, and x6=0xBB while in HOLD. Expect a=0xAA, and b=0xBB on the next cycle. A write of 0xFF to x0 causes no change.
- **Backpressure and back-to-back:** hold `out_ready`=0 for 5 cycles; expect outputs stable and `in_ready`=0. Then raise `out_ready` with `in_valid` and nsrc=0; expect the new bundle on the next cycle with no IDLE gap.
- **Reset mid-READ:** assert `rst` at T+2 of an nsrc=3 instruction. Expect IDLE with `out_valid`=0 and `rf_adr`=0 the next cycle, and a fresh accept to work normally.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared widths and collector state encoding for the CUDA core.
package core_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;
  localparam int NUM_SRC = 3;
  typedef enum logic [1:0] {IDLE, READ, HOLD} oc_state_t;
endpackage

// File: rtl/oc_slot.sv
// oc_slot: one operand register with its source index and writeback snoop.
module oc_slot #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [REG_AW-1:0] new_src,
  input  logic              capture,
  input  logic              snoop_en,
  input  logic [XLEN-1:0]   rf_rs,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_adr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] src,
  output logic [XLEN-1:0]   val
);
  logic filled;
  logic hit;
  assign hit = snoop_en && wb_we && wb_adr != '0 && wb_adr == src;
  // unfilled slots ignore the snoop, so slots past nsrc stay zero
  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
      src <= '0;
      filled <= 1'b0;
    end else if (clr) begin
      val <= '0;
      src <= new_src;
      filled <= 1'b0;
    end else if (capture) begin
      val <= src == '0 ? '0 : hit ? wb_data : rf_rs;
      filled <= 1'b1;
    end else if (filled && hit) begin
      val <= wb_data;
    end
  end
endmodule

// File: rtl/operand_collector.sv
// operand_collector: serialises up to three source reads onto one RF port and
// presents a snoop-coherent operand bundle to execute.
module operand_collector
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int REG_AW = core_pkg::REG_AW,
  parameter int CTRL_W = core_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_nsrc,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rs3,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [REG_AW-1:0] rf_adr,
  input  logic [XLEN-1:0]   rf_rs,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_adr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [XLEN-1:0]   out_c,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl
);
  oc_state_t state;
  logic [1:0] idx;
  logic [1:0] nsrc;
  logic accept;
  logic [REG_AW-1:0] rs_in [NUM_SRC];
  logic [REG_AW-1:0] src [NUM_SRC];
  logic [XLEN-1:0] val [NUM_SRC];
  assign in_ready = !rst && (state == IDLE || (state == HOLD && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state == HOLD;
  assign rs_in[0] = in_rs1;
  assign rs_in[1] = in_rs2;
  assign rs_in[2] = in_rs3;
  assign out_a = val[0];
  assign out_b = val[1];
  assign out_c = val[2];
  always_comb
    rf_adr = state != READ ? '0 : idx == 2'd2 ? src[2] : idx == 2'd1 ? src[1] : src[0];
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    oc_slot #(.XLEN(XLEN), .REG_AW(REG_AW)) u_slot (
      .clk(clk),
      .rst(rst),
      .clr(accept),
      .new_src(rs_in[i]),
      .capture(state == READ && idx == 2'(i)),
      .snoop_en(state != IDLE),
      .rf_rs(rf_rs),
      .wb_we(wb_we),
      .wb_adr(wb_adr),
      .wb_data(wb_data),
      .src(src[i]),
      .val(val[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      nsrc <= '0;
      out_rd <= '0;
      out_imm <= '0;
      out_ctrl <= '0;
    end else if (accept) begin
      state <= in_nsrc != 2'd0 ? READ : HOLD;
      idx <= '0;
      nsrc <= in_nsrc;
      out_rd <= in_rd;
      out_imm <= in_imm;
      out_ctrl <= in_ctrl;
    end else if (state == READ) begin
      idx <= idx + 2'd1;
      if (idx == nsrc - 2'd1) state <= HOLD;
    end else if (state == HOLD && out_ready) begin
      state <= IDLE;
    end
  end
endmodule
